// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline definitions: default stage payload width and the occupancy helper
// used by the stage buffers.
package pipe_stage_buf_pkg;

  localparam int PSB_DEFAULT_W = 16;

  function automatic logic [1:0] occupancy(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/dff.sv
// Single-bit enabled flop with synchronous active-high clear; the storage cell every
// pipeline register is built from. Latency 1, no backpressure.
module dff (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_slot.sv
// One pipeline entry: WIDTH-bit payload plus valid, with load, clear and hold.
// Clear wins over load; payload flops only toggle on a real load.
module pipe_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic valid_d;
  logic data_en;

  assign valid_d = !clear && (load || valid);
  assign data_en = load && !clear;

  dff u_valid (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (valid_d),
    .q   (valid)
  );

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    dff u_bit (
      .clk (clk),
      .rst (rst),
      .en  (data_en),
      .d   (load_data[b]),
      .q   (data[b])
    );
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready, flush and optional skid entry; 1-cycle latency,
// stall by back-pressure (registered in_ready when SKID=1, combinational when SKID=0).
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH = PSB_DEFAULT_W,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic accept;
  logic consume;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  if (SKID == 0) begin : g_single
    logic main_load;
    logic main_clear;

    assign in_ready   = !out_valid || out_ready;
    assign main_load  = accept && !flush;
    assign main_clear = flush || (consume && !accept);

    pipe_slot #(.WIDTH(WIDTH)) u_main (
      .clk       (clk),
      .rst       (rst),
      .load      (main_load),
      .clear     (main_clear),
      .load_data (in_data),
      .valid     (out_valid),
      .data      (out_data)
    );

    assign count = occupancy(out_valid, 1'b0);
  end else begin : g_skid
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             main_load;
    logic             main_clear;
    logic [WIDTH-1:0] main_src;
    logic             skid_load;
    logic             skid_clear;

    assign in_ready = !skid_valid;

    // When the skid holds an entry it is always older than in_data, so it refills main first.
    assign main_src   = skid_valid ? skid_data : in_data;
    assign main_load  = !flush && (skid_valid ? consume
                                              : (accept && (!out_valid || consume)));
    assign main_clear = flush || (consume && !accept && !skid_valid);

    assign skid_load  = !flush && out_valid && !skid_valid && accept && !consume;
    assign skid_clear = flush || (skid_valid && consume);

    pipe_slot #(.WIDTH(WIDTH)) u_main (
      .clk       (clk),
      .rst       (rst),
      .load      (main_load),
      .clear     (main_clear),
      .load_data (main_src),
      .valid     (out_valid),
      .data      (out_data)
    );

    pipe_slot #(.WIDTH(WIDTH)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (skid_load),
      .clear     (skid_clear),
      .load_data (in_data),
      .valid     (skid_valid),
      .data      (skid_data)
    );

    assign count = occupancy(out_valid, skid_valid);
  end

endmodule
